tug_scoreboard: RTL and testbench

Game-state stage that consumes the single-cycle push pulses produced by each player's edge-detect (one-pulse) stage. It keeps the rope position, steps it one LED toward the player who pulled, declares a round winner when an end LED is reached, and keeps saturating per-player win counts. It drives the LED bar and score outputs directly.

---
 rtl/tug_scoreboard.sv | 176 +++++++++++++++++
 tb/tb_tug_scoreboard.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/tug_scoreboard.sv
//============================================================================
// Module   : tug_scoreboard
// Purpose  : Tug-of-war game state. Consumes one-cycle push pulses from both
//            players, steps the rope position, declares round winners and
//            keeps saturating per-player win counts. Drives the LED bar and
//            score outputs from registers.
// Options  : TUG_FLASH_EN - when defined, the winner's end LED flashes with
//            a period of 2*FLASH_DIV cycles instead of staying steady.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tug_scoreboard #(
  parameter int NPOS      = 9,
  parameter int SCW       = 4,
  parameter int FLASH_DIV = 12500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic            lpush,
  input  logic            rpush,
  input  logic            clr_score,
  output logic [NPOS-1:0] leds,
  output logic [SCW-1:0]  lscore,
  output logic [SCW-1:0]  rscore,
  output logic            playing,
  output logic            lwin,
  output logic            rwin
);

  localparam int PW = $clog2(NPOS);
  localparam int C  = (NPOS - 1) / 2;
  localparam logic [PW-1:0]  POS_C    = PW'(C);
  localparam logic [PW-1:0]  POS_ONE  = PW'(1);
  localparam logic [PW-1:0]  POS_PRE  = PW'(NPOS - 2);
  localparam logic [PW-1:0]  POS_END  = PW'(NPOS - 1);
  localparam logic [SCW-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    READY = 2'd0,
    PLAY  = 2'd1,
    WIN_L = 2'd2,
    WIN_R = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] pos;

  function automatic logic [NPOS-1:0] onehot(input logic [PW-1:0] p);
    return {{(NPOS-1){1'b0}}, 1'b1} << p;
  endfunction

  // A simultaneous pull from both sides cancels out.
  logic move_l, move_r, land_l, land_r, in_win, flash_lit_next;
  assign move_l = lpush & ~rpush;
  assign move_r = rpush & ~lpush;
  // In PLAY the rope never sits on an end, so only pos 1 / NPOS-2 can win.
  assign land_l = (state == PLAY) && move_l && (pos == POS_ONE);
  assign land_r = (state == PLAY) && move_r && (pos == POS_PRE);
  assign in_win = (state == WIN_L) || (state == WIN_R);

`ifdef TUG_FLASH_EN
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [FW-1:0] CNT_LAST = FW'(FLASH_DIV - 1);

  logic [FW-1:0] flash_cnt;
  logic          flash_phase;

  // Lit/dark value the end LED takes on the next edge while still winning.
  assign flash_lit_next = (flash_cnt == CNT_LAST) ? ~flash_phase : flash_phase;

  // Flash timebase: restarts lit on win entry, idle outside the win states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b1;
    end else if (in_win && !go) begin
      if (flash_cnt == CNT_LAST) begin
        flash_cnt   <= '0;
        flash_phase <= ~flash_phase;
      end else begin
        flash_cnt <= flash_cnt + FW'(1);
      end
    end else begin
      flash_cnt   <= '0;
      flash_phase <= 1'b1;
    end
  end
`else
  // Steady end LED; the divider only matters when flashing is built in.
  localparam logic STEADY_ON = 1'b1 | (FLASH_DIV == 0);
  assign flash_lit_next = STEADY_ON;
`endif

  // Game FSM with registered position, LED bar and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= READY;
      pos     <= POS_C;
      leds    <= onehot(POS_C);
      playing <= 1'b0;
      lwin    <= 1'b0;
      rwin    <= 1'b0;
    end else begin
      case (state)
        READY: begin
          if (go) begin
            state   <= PLAY;
            playing <= 1'b1;
          end
        end
        PLAY: begin
          if (move_l) begin
            pos  <= pos - POS_ONE;
            leds <= onehot(pos - POS_ONE);
            if (land_l) begin
              state   <= WIN_L;
              playing <= 1'b0;
              lwin    <= 1'b1;
            end
          end else if (move_r) begin
            pos  <= pos + POS_ONE;
            leds <= onehot(pos + POS_ONE);
            if (land_r) begin
              state   <= WIN_R;
              playing <= 1'b0;
              rwin    <= 1'b1;
            end
          end
        end
        WIN_L, WIN_R: begin
          if (go) begin
            state   <= PLAY;
            pos     <= POS_C;
            leds    <= onehot(POS_C);
            playing <= 1'b1;
            lwin    <= 1'b0;
            rwin    <= 1'b0;
          end else begin
            leds <= flash_lit_next ? onehot(pos) : '0;
          end
        end
        default: begin
          state   <= READY;
          pos     <= POS_C;
          leds    <= onehot(POS_C);
          playing <= 1'b0;
          lwin    <= 1'b0;
          rwin    <= 1'b0;
        end
      endcase
    end
  end

  // Win counters: clear has priority over a coincident win, counts saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lscore <= '0;
      rscore <= '0;
    end else if (clr_score) begin
      lscore <= '0;
      rscore <= '0;
    end else begin
      if (land_l && lscore != SCORE_MAX) lscore <= lscore + SCW'(1);
      if (land_r && rscore != SCORE_MAX) rscore <= rscore + SCW'(1);
    end
  end

  // The end position is fixed by construction; keep it referenced for clarity.
  logic unused_end;
  assign unused_end = ^POS_END;

endmodule

`default_nettype wire

// File: tb/tb_tug_scoreboard.sv
`default_nettype none

module tb_tug_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0, lpush = 1'b0, rpush = 1'b0, clr_score = 1'b0;
  logic [8:0] leds;
  logic [1:0] lscore, rscore;
  logic       playing, lwin, rwin;

  int total = 0;
  int fails = 0;

  tug_scoreboard #(.NPOS(9), .SCW(2), .FLASH_DIV(4)) dut (
    .clk(clk), .rst(rst), .go(go), .lpush(lpush), .rpush(rpush),
    .clr_score(clr_score), .leds(leds), .lscore(lscore), .rscore(rscore),
    .playing(playing), .lwin(lwin), .rwin(rwin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then return them low; checks follow the edge.
  task automatic step(input logic g, input logic l, input logic r, input logic c);
    @(negedge clk);
    go = g; lpush = l; rpush = r; clr_score = c;
    @(negedge clk);
    go = 1'b0; lpush = 1'b0; rpush = 1'b0; clr_score = 1'b0;
  endtask

  // Hold rpush for four cycles from the centre: 5,6,7,8 -> right win.
  task automatic right_win(input logic clr_last);
    @(negedge clk);
    rpush = 1'b1;
    repeat (3) @(negedge clk);
    clr_score = clr_last;
    @(negedge clk);
    rpush = 1'b0; clr_score = 1'b0;
  endtask

  initial begin
    logic [8:0] exp_led;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_leds", 32'(leds), 32'h010);
    chk("reset_lscore", 32'(lscore), 0);
    chk("reset_rscore", 32'(rscore), 0);
    chk("reset_playing", 32'(playing), 0);
    chk("reset_lwin", 32'(lwin), 0);
    chk("reset_rwin", 32'(rwin), 0);

    // Pushes in READY are ignored.
    step(0, 1, 0, 0);
    chk("ready_push_leds", 32'(leds), 32'h010);
    chk("ready_push_playing", 32'(playing), 0);

    step(1, 0, 0, 0);
    chk("go_playing", 32'(playing), 1);
    chk("go_leds", 32'(leds), 32'h010);

    // Four spaced left pulls walk the rope to bit 0.
    step(0, 1, 0, 0); chk("lpush1_leds", 32'(leds), 32'h008);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); chk("lpush2_leds", 32'(leds), 32'h004);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); chk("lpush3_leds", 32'(leds), 32'h002);
    chk("lpush3_lwin", 32'(lwin), 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); chk("lpush4_leds", 32'(leds), 32'h001);
    chk("lwin_set", 32'(lwin), 1);
    chk("lwin_playing", 32'(playing), 0);
    chk("lwin_lscore", 32'(lscore), 1);

    // Pushes in WIN_L do nothing.
    step(0, 0, 1, 0);
    chk("winl_push_lwin", 32'(lwin), 1);
    chk("winl_push_rscore", 32'(rscore), 0);

    step(1, 0, 0, 0);
    chk("next_round_playing", 32'(playing), 1);
    chk("next_round_leds", 32'(leds), 32'h010);
    chk("next_round_lwin", 32'(lwin), 0);
    chk("next_round_lscore", 32'(lscore), 1);

    // Simultaneous pulls cancel.
    step(0, 1, 1, 0); chk("both_leds", 32'(leds), 32'h010);
    step(0, 0, 1, 0); chk("rpush_leds", 32'(leds), 32'h020);
    step(0, 0, 1, 0); chk("rpush2_leds", 32'(leds), 32'h040);
    step(0, 0, 1, 0); chk("rpush3_leds", 32'(leds), 32'h080);
    @(negedge clk); rpush = 1'b1;
    @(negedge clk); rpush = 1'b0;
    chk("rwin_leds", 32'(leds), 32'h100);
    chk("rwin_set", 32'(rwin), 1);
    chk("rwin_rscore", 32'(rscore), 1);

    // End LED behaviour for the following edges after the win edge.
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
`ifdef TUG_FLASH_EN
      exp_led = (((k / 4) % 2) == 0) ? 9'h100 : 9'h000;
`else
      exp_led = 9'h100;
`endif
      chk($sformatf("win_led_k%0d", k), 32'(leds), 32'(exp_led));
    end

    // Pushes in WIN_R are ignored; go with a push starts from centre.
    step(0, 1, 0, 0);
    chk("winr_push_rwin", 32'(rwin), 1);
    chk("winr_push_rscore", 32'(rscore), 1);
    step(1, 1, 0, 0);
    chk("winr_go_playing", 32'(playing), 1);
    chk("winr_go_leds", 32'(leds), 32'h010);
    chk("winr_go_rscore", 32'(rscore), 1);

    // Saturating right score with SCW=2.
    right_win(0); chk("sat_win2", 32'(rscore), 2);
    step(1, 0, 0, 0);
    right_win(0); chk("sat_win3", 32'(rscore), 3);
    step(1, 0, 0, 0);
    right_win(0); chk("sat_win4", 32'(rscore), 3);
    step(1, 0, 0, 0);
    right_win(0); chk("sat_win5", 32'(rscore), 3);
    chk("sat_rwin", 32'(rwin), 1);

    // Clear coinciding with a win edge wins over the increment.
    step(1, 0, 0, 0);
    right_win(1);
    chk("clr_win_rscore", 32'(rscore), 0);
    chk("clr_win_lscore", 32'(lscore), 0);
    chk("clr_win_rwin", 32'(rwin), 1);

    // Asynchronous reset mid-win takes effect without a clock edge.
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_leds", 32'(leds), 32'h010);
    chk("arst_rwin", 32'(rwin), 0);
    chk("arst_playing", 32'(playing), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

`default_nettype wire
